// File: rtl/cordic_sincos_pipe_if.sv
// Angle-in / sine-cosine-out bus of the pipelined CORDIC generator.
// master feeds angles and consumes results; slave is the generator side.
interface cordic_sincos_pipe_if #(
  parameter int W = 8
);
  logic                in_valid;
  logic signed [W-1:0] angle;
  logic                out_valid;
  logic signed [W-1:0] cosine;
  logic signed [W-1:0] sine;

  modport master (output in_valid, output angle, input out_valid, input cosine, input sine);
  modport slave  (input in_valid, input angle, output out_valid, output cosine, output sine);
endinterface

// File: rtl/cordic_sincos_pipe.sv
// Pipelined rotation-mode CORDIC sin/cos, STAGES+2 enabled clocks latency, ce low stalls the whole pipe.
// CORDIC_ROUND_EN: output rounds half up instead of truncating toward -inf.
module cordic_sincos_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 8,
  parameter int G      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  cordic_sincos_pipe_if.slave bus
);
  localparam int F  = W - 1 + G;
  localparam int XW = F + 2;
  localparam int ZF = W - 3 + G;
  localparam int ZW = ZF + 3;

  typedef logic signed [XW-1:0]      xy_t;
  typedef logic signed [ZW-1:0]      z_t;
  typedef logic signed [XW:0]        wide_t;
  typedef logic [STAGES-1:0][ZW-1:0] atan_tab_t;

  function automatic atan_tab_t build_atan();
    atan_tab_t tab;
    tab = '0;
    for (int i = 0; i < STAGES; i++)
      tab[i] = ZW'($rtoi($atan(2.0 ** (-i)) * (2.0 ** ZF) + 0.5));
    return tab;
  endfunction

  localparam atan_tab_t ATAN      = build_atan();
  localparam xy_t       X0        = xy_t'($rtoi(0.6072529350 * (2.0 ** F) + 0.5));
  localparam z_t        PI_Z      = z_t'($rtoi(3.14159265358979 * (2.0 ** ZF) + 0.5));
  localparam z_t        HALF_PI_Z = z_t'($rtoi(1.57079632679490 * (2.0 ** ZF) + 0.5));
  localparam wide_t     OUT_MAX   = wide_t'((2 ** (W-1)) - 1);
  localparam wide_t     OUT_MIN   = wide_t'(-(2 ** (W-1)));

  // Drop the guard bits (optionally rounding) and clamp into the output range.
  function automatic logic signed [W-1:0] to_out(input xy_t v);
    wide_t t;
    wide_t sh;
    logic signed [W-1:0] res;
    t = wide_t'(v);
`ifdef CORDIC_ROUND_EN
    t = t + wide_t'(2 ** (G-1));
`endif
    sh = t >>> G;
    if (sh > OUT_MAX)
      res = OUT_MAX[W-1:0];
    else if (sh < OUT_MIN)
      res = OUT_MIN[W-1:0];
    else
      res = sh[W-1:0];
    return res;
  endfunction

  xy_t                 x_q [STAGES+1];
  xy_t                 y_q [STAGES+1];
  z_t                  z_q [STAGES];
  logic [STAGES:0]     neg_q;
  logic [STAGES:0]     vld_q;
  logic signed [W-1:0] cos_q;
  logic signed [W-1:0] sin_q;
  logic                out_vld_q;

  z_t   z_in;
  z_t   z_pre;
  logic neg_pre;
  xy_t  x_fin;
  xy_t  y_fin;

  assign z_in = z_t'(bus.angle) <<< G;

  // Fold angles beyond +-pi/2 back by pi; the result is negated at the output.
  always_comb begin
    z_pre   = z_in;
    neg_pre = 1'b0;
    if (z_in > HALF_PI_Z) begin
      z_pre   = z_in - PI_Z;
      neg_pre = 1'b1;
    end else if (z_in < -HALF_PI_Z) begin
      z_pre   = z_in + PI_Z;
      neg_pre = 1'b1;
    end
  end

  always_comb begin
    x_fin = neg_q[STAGES] ? -x_q[STAGES] : x_q[STAGES];
    y_fin = neg_q[STAGES] ? -y_q[STAGES] : y_q[STAGES];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s <= STAGES; s++) begin
        x_q[s] <= '0;
        y_q[s] <= '0;
      end
      for (int s = 0; s < STAGES; s++)
        z_q[s] <= '0;
      neg_q     <= '0;
      vld_q     <= '0;
      cos_q     <= '0;
      sin_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (ce) begin
      x_q[0]   <= X0;
      y_q[0]   <= '0;
      z_q[0]   <= z_pre;
      neg_q[0] <= neg_pre;
      vld_q[0] <= bus.in_valid;
      for (int s = 1; s <= STAGES; s++) begin
        if (z_q[s-1][ZW-1]) begin
          x_q[s] <= x_q[s-1] + (y_q[s-1] >>> (s-1));
          y_q[s] <= y_q[s-1] - (x_q[s-1] >>> (s-1));
        end else begin
          x_q[s] <= x_q[s-1] - (y_q[s-1] >>> (s-1));
          y_q[s] <= y_q[s-1] + (x_q[s-1] >>> (s-1));
        end
        neg_q[s] <= neg_q[s-1];
        vld_q[s] <= vld_q[s-1];
      end
      // The last iteration's residual angle is never consumed, so z stops one stage early.
      for (int s = 1; s < STAGES; s++)
        z_q[s] <= z_q[s-1][ZW-1] ? z_q[s-1] + z_t'(ATAN[s-1]) : z_q[s-1] - z_t'(ATAN[s-1]);
      cos_q     <= to_out(x_fin);
      sin_q     <= to_out(y_fin);
      out_vld_q <= vld_q[STAGES];
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.cosine    = cos_q;
  assign bus.sine      = sin_q;
endmodule

// File: tb/tb_cordic_sincos_pipe.sv
// Self-checking bench for cordic_sincos_pipe (W=8, STAGES=8, G=2): directed vectors, sweep, stall, async reset.
module tb_cordic_sincos_pipe;
  localparam int LAT = 10;

  typedef struct {
    int angle;
    int cos_lo;
    int cos_hi;
    int sin_lo;
    int sin_hi;
    int due;
  } exp_t;

  logic clk;
  logic rst;
  logic ce;

  cordic_sincos_pipe_if #(.W(8)) bus ();

  cordic_sincos_pipe #(.W(8), .STAGES(8), .G(2)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   ecnt  = 0;
  int   n_pop = 0;
  exp_t sb [$];
  exp_t last;
  logic last_vld = 1'b0;
  exp_t vecs [3];

  task automatic chk(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  function automatic int rnd(input real r);
    int v;
    if (r >= 0.0) v = $rtoi(r + 0.5);
    else          v = -$rtoi(-r + 0.5);
    return v;
  endfunction

  function automatic exp_t model_exp(input int a);
    exp_t e;
    int   c;
    int   s;
    int   tol;
    real  ang;
`ifdef CORDIC_ROUND_EN
    tol = 1;
`else
    tol = 2;
`endif
    ang = real'(a) / 32.0;
    c = rnd(127.99 * $cos(ang));
    s = rnd(127.99 * $sin(ang));
    e.angle  = a;
    e.cos_lo = c - tol;
    e.cos_hi = c + tol;
    e.sin_lo = s - tol;
    e.sin_hi = s + tol;
    e.due    = 0;
    return e;
  endfunction

  // One clock: drive at negedge, sample 2 time units after the rising edge.
  task automatic tick(input logic v, input exp_t e, input logic c);
    exp_t ne;
    logic exp_vld;
    @(negedge clk);
    bus.in_valid = v;
    bus.angle    = 8'(e.angle);
    ce           = c;
    if (c && v) begin
      ne     = e;
      ne.due = ecnt + LAT;
      sb.push_back(ne);
    end
    @(posedge clk);
    if (c) ecnt++;
    #2;
    if (c) begin
      exp_vld = (sb.size() > 0) && (sb[0].due == ecnt);
      if (exp_vld) begin
        last = sb.pop_front();
        n_pop++;
      end
      last_vld = exp_vld;
    end
    chk("out_valid", int'(bus.out_valid), int'(last_vld), int'(last_vld));
    if (last_vld) begin
      chk($sformatf("cosine[a=%0d]", last.angle), int'(bus.cosine), last.cos_lo, last.cos_hi);
      chk($sformatf("sine[a=%0d]", last.angle), int'(bus.sine), last.sin_lo, last.sin_hi);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < LAT + 2; i++) tick(1'b0, model_exp(0), 1'b1);
    chk("queue_drained", sb.size(), 0, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    vecs[0] = '{angle: 0,    cos_lo: 127,  cos_hi: 127,  sin_lo: -2,  sin_hi: 2,   due: 0};
    vecs[1] = '{angle: 50,   cos_lo: -1,   cos_hi: 3,    sin_lo: 125, sin_hi: 127, due: 0};
    vecs[2] = '{angle: -101, cos_lo: -128, cos_hi: -126, sin_lo: 0,   sin_hi: 4,   due: 0};

    rst          = 1'b0;
    ce           = 1'b1;
    bus.in_valid = 1'b0;
    bus.angle    = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_out_valid", int'(bus.out_valid), 0, 0);
    chk("reset_cosine", int'(bus.cosine), 0, 0);
    chk("reset_sine", int'(bus.sine), 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 3; i++) tick(1'b1, vecs[i], 1'b1);
    flush();

    // Async reset mid-stream, while a valid result is on the outputs
    tick(1'b1, vecs[0], 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, model_exp(16 + i), 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, model_exp(0), 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("arst_out_valid", int'(bus.out_valid), 0, 0);
    chk("arst_cosine", int'(bus.cosine), 0, 0);
    chk("arst_sine", int'(bus.sine), 0, 0);
    #2 rst = 1'b1;
    sb.delete();
    last_vld = 1'b0;
    tick(1'b1, model_exp(30), 1'b1);
    flush();

    // Full sweep, one code per clock
    n0 = n_pop;
    for (int a = -128; a <= 127; a++) tick(1'b1, model_exp(a), 1'b1);
    flush();
    chk("sweep_count", n_pop - n0, 256, 256);

    // Bubbles every 4th cycle plus a 5-clock ce stall
    n0 = n_pop;
    for (int k = 0; k < 40; k++)
      tick((k % 4) != 3, model_exp(k * 5 - 100), !(k >= 15 && k < 20));
    flush();
    chk("stall_count", n_pop - n0, 27, 27);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cordic_sincos_pipe.md
Name: cordic_sincos_pipe

Overview:
- Parametrised, fully pipelined rotation-mode CORDIC sine/cosine generator; successor to the fixed 8-bit core.
- Generalised in data width, iteration count and guard bits.
- Adds full-range angle input (|angle| up to 4 rad) via quadrant pre-rotation, a valid pipeline and a clock-enable stall.
- Sits between the phase accumulator / angle source and downstream DSP consumers; one sample per clock.

Parameters:
- W, 8, angle/output width in bits.
- STAGES, 8, CORDIC iterations; legal range 4..W+G.
- G, 2, internal guard bits added to the datapath fraction.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous active-low reset.
- ce  input  1  clock enable; low = whole pipeline holds.
- in_valid  input  1  qualifies angle.
- angle  input  W  signed angle, radians, Q3.(W-3); full code range accepted.
- out_valid  output  1  qualifies sine/cosine.
- cosine  output  W  signed Q1.(W-1).
- sine  output  W  signed Q1.(W-1).

Behaviour:
- Reset:
  - rst low clears every pipeline register immediately (asynchronous).
  - out_valid=0, sine=0, cosine=0 while rst is low.
  - Reset mid-stream drops all in-flight samples.
  - After release, the first out_valid appears only for samples accepted after release.
- Internal format:
  - F = W-1+G fraction bits; x/y width F+2, two's complement.
  - z holds W-3+G fraction bits plus sign and 2 integer bits.
  - Constants computed at elaboration: atan(2^-i) rounded to nearest; x0 = round(0.6072529350 * 2^F); y0 = 0.
- Stage 0 (input register, quadrant pre-rotation):
  - angle > +pi/2: z = angle - pi, neg = 1.
  - angle < -pi/2: z = angle + pi, neg = 1.
  - Otherwise: z = angle, neg = 0.
  - Exactly ±pi/2 (after quantisation) takes the no-correction path.
  - pi and pi/2 constants are rounded to the z format.
- Stages 1..STAGES: iteration i = stage-1.
  - d = +1 if z >= 0, else -1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan_i.
  - Arithmetic shifts; no wrap is possible within F+2 bits.
  - neg and valid travel alongside the data.
- Output stage:
  - Negate x and y if neg.
  - Drop G guard bits: truncate toward -inf (default).
  - Saturate to [-2^(W-1), 2^(W-1)-1]; +1.0 maps to 2^(W-1)-1.
- Latency:
  - Exactly STAGES+2 enabled clocks from in_valid/angle sampled to out_valid/result.
  - Throughput: one sample per enabled clock.
- ce=0: every register (data, neg, valid) holds. Outputs are frozen; no sample is lost or duplicated.
- in_valid=0 with ce=1: a bubble propagates; out_valid=0 for that slot. Data registers still update and are don't-care.
- Accuracy: |error| <= 2 LSB of output for every angle code with W=8, STAGES=8, G=2.

Optional Feature:
- Macro: CORDIC_ROUND_EN.
- Defined: the output stage adds 2^(G-1) before dropping guard bits (round half up), then saturates. Accuracy requirement tightens to <= 1 LSB. Latency is unchanged.
- Undefined: truncation as above.

Test Plan:
- Async reset pulse mid-stream (rst low 3 ns between clock edges):
  - Outputs and out_valid go to 0 without a clock edge.
  - Next out_valid appears exactly STAGES+2 = 10 clocks after the first post-reset in_valid.
- angle=0, in_valid=1 (W=8):
  - After 10 clocks: cosine=127 (saturated), sine in [-2,2], out_valid=1.
- angle=50 (1.5625 rad):
  - cosine in [-1,3], sine in [125,127].
- angle=-101 (-3.156 rad, lower-left correction path):
  - cosine in [-128,-126], sine in [0,4].
- Continuous sweep of codes -128..127, one per clock, ce=1:
  - 256 out_valid pulses in order.
  - Each result within 2 LSB of round(127.99*cos/sin) (1 LSB with CORDIC_ROUND_EN).
- ce held low 5 clocks mid-sweep, plus in_valid=0 gaps every 4th cycle:
  - Outputs frozen during the stall.
  - out_valid pattern equals the input valid pattern delayed by 10 enabled clocks; no repeats or drops.
